// File: rtl/param_cruncher_pkg.sv
// Shared types for the param_cruncher micro-sequencer: opcodes, FSM states and
// instruction field offsets as functions of the datapath and register widths.
package param_cruncher_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,  OP_LDI = 4'd1,  OP_IN  = 4'd2,  OP_MOV = 4'd3,
    OP_ADD = 4'd4,  OP_SUB = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
    OP_XOR = 4'd8,  OP_OUT = 4'd9,  OP_JMP = 4'd10, OP_JZ  = 4'd11,
    OP_JC  = 4'd12, OP_HLT = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  // Instruction layout, MSB to LSB: {op[3:0], rd[RW], rs[RW], imm[DW]}
  function automatic int instr_w(int dw, int rw);
    return 4 + 2 * rw + dw;
  endfunction

  function automatic int op_lsb(int dw, int rw);
    return dw + 2 * rw;
  endfunction

  function automatic int rd_lsb(int dw, int rw);
    return dw + rw;
  endfunction

  function automatic int rs_lsb(int dw);
    return dw;
  endfunction

endpackage

// File: rtl/cruncher_alu.sv
// Combinational ALU: result, carry/borrow and zero for the flag-setting ops.
module cruncher_alu
  import param_cruncher_pkg::*;
#(
  parameter int DW = 4
) (
  input  opcode_e       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] res,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] sum;

  // Bit DW of the widened difference is the unsigned borrow (a < b)
  always_comb begin
    sum = '0;
    case (op)
      OP_ADD:  sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  sum = {1'b0, a} - {1'b0, b};
      OP_AND:  sum = {1'b0, a & b};
      OP_OR:   sum = {1'b0, a | b};
      OP_XOR:  sum = {1'b0, a ^ b};
      default: sum = {1'b0, a};
    endcase
  end

  assign res   = sum[DW-1:0];
  assign carry = sum[DW];
  assign zero  = (res == '0);

endmodule

// File: rtl/param_cruncher.sv
// Two-cycle-per-instruction micro-sequencer: FETCH latches mem[pc], EXEC
// executes it. Program memory is writable only while not busy.
module param_cruncher
  import param_cruncher_pkg::*;
#(
  parameter int DW     = 4,
  parameter int NREG   = 4,
  parameter int PDEPTH = 16,
  parameter int RW     = $clog2(NREG),
  parameter int AW     = $clog2(PDEPTH),
  parameter int IW     = instr_w(DW, RW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_wdata,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] pc,
  output logic [IW-1:0] op_code,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy,
  output logic          halted
);

  localparam int OP_LSB = op_lsb(DW, RW);
  localparam int RD_LSB = rd_lsb(DW, RW);
  localparam int RS_LSB = rs_lsb(DW);

  state_e                   state;
  logic [IW-1:0]            mem [PDEPTH];
  logic [NREG-1:0][DW-1:0]  rf;

  opcode_e       op;
  logic [RW-1:0] rd, rs;
  logic [DW-1:0] imm, rd_val, rs_val, alu_res;
  logic [AW-1:0] pc_inc, tgt;
  logic          alu_c, alu_z;

  assign op     = opcode_e'(op_code[OP_LSB +: 4]);
  assign rd     = op_code[RD_LSB +: RW];
  assign rs     = op_code[RS_LSB +: RW];
  assign imm    = op_code[DW-1:0];
  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign pc_inc = pc + AW'(1);
  assign tgt    = AW'(imm);

  cruncher_alu #(.DW(DW)) u_alu (
    .op   (op),
    .a    (rd_val),
    .b    (rs_val),
    .res  (alu_res),
    .carry(alu_c),
    .zero (alu_z)
  );

  // Program memory keeps its contents across reset
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_HALT))
      mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      op_code  <= '0;
      rf       <= '0;
      out_data <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            pc     <= '0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          op_code <= mem[pc];
          state   <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          pc    <= pc_inc;
          case (op)
            OP_LDI: rf[rd] <= imm;
            OP_IN:  rf[rd] <= in_data;
            OP_MOV: rf[rd] <= rs_val;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              rf[rd] <= alu_res;
              flag_z <= alu_z;
              flag_c <= alu_c;
            end
            OP_OUT: out_data <= rd_val;
            OP_JMP: pc <= tgt;
            OP_JZ:  if (flag_z) pc <= tgt;
            OP_JC:  if (flag_c) pc <= tgt;
            OP_HLT: begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cruncher.sv
// Bench for param_cruncher: directed programs plus random programs, checked
// instruction by instruction against an interpreter of the instruction set.
module tb_param_cruncher;

  localparam int DW     = 4;
  localparam int NREG   = 4;
  localparam int PDEPTH = 16;
  localparam int RW     = $clog2(NREG);
  localparam int AW     = $clog2(PDEPTH);
  localparam int IW     = 4 + 2 * RW + DW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_wdata = '0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] pc;
  logic [IW-1:0] op_code;
  logic          flag_z, flag_c, busy, halted;

  param_cruncher #(.DW(DW), .NREG(NREG), .PDEPTH(PDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .in_data(in_data),
    .out_data(out_data), .pc(pc), .op_code(op_code), .flag_z(flag_z),
    .flag_c(flag_c), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;

  // Reference machine state
  int m_mem [PDEPTH];
  int m_r   [NREG];
  int m_pc, m_out, m_z, m_c, m_halt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(int op, int rd, int rs, int imm);
    int v;
    v = op * 256 + rd * 64 + rs * 16 + imm;
    return v[IW-1:0];
  endfunction

  // Interpret one instruction at m_pc using plain integer arithmetic
  task automatic m_step();
    int w, op, rd, rs, imm, a, b, r, nxt, lim;
    lim = 1 << DW;
    w   = m_mem[m_pc];
    op  = w / 256;
    rd  = (w / 64) % 4;
    rs  = (w / 16) % 4;
    imm = w % 16;
    a   = m_r[rd];
    b   = m_r[rs];
    nxt = (m_pc + 1) % PDEPTH;
    case (op)
      1: m_r[rd] = imm;
      2: m_r[rd] = int'(in_data);
      3: m_r[rd] = b;
      4: begin r = a + b; m_c = (r >= lim) ? 1 : 0; m_r[rd] = r % lim; m_z = (m_r[rd] == 0) ? 1 : 0; end
      5: begin m_c = (a < b) ? 1 : 0; m_r[rd] = (a - b + lim) % lim; m_z = (m_r[rd] == 0) ? 1 : 0; end
      6: begin m_r[rd] = a & b; m_c = 0; m_z = (m_r[rd] == 0) ? 1 : 0; end
      7: begin m_r[rd] = a | b; m_c = 0; m_z = (m_r[rd] == 0) ? 1 : 0; end
      8: begin m_r[rd] = a ^ b; m_c = 0; m_z = (m_r[rd] == 0) ? 1 : 0; end
      9: m_out = a;
      10: nxt = imm % PDEPTH;
      11: if (m_z != 0) nxt = imm % PDEPTH;
      12: if (m_c != 0) nxt = imm % PDEPTH;
      13: m_halt = 1;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks the async clear
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_opcode", int'(op_code), 0);
    chk("rst_out", int'(out_data), 0);
    chk("rst_z", int'(flag_z), 0);
    chk("rst_c", int'(flag_c), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    foreach (m_r[i]) m_r[i] = 0;
    m_pc = 0; m_out = 0; m_z = 0; m_c = 0; m_halt = 0;
  endtask

  task automatic load(input int a, input logic [IW-1:0] w);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = w;
    @(posedge clk); @(negedge clk);
    prog_we = 1'b0;
    m_mem[a] = int'(w);
  endtask

  task automatic start_run(input int we = 0, input int a = 0, input logic [IW-1:0] w = '0);
    start = 1'b1;
    if (we != 0) begin prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = w; end
    @(posedge clk); @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    if (we != 0) m_mem[a] = int'(w);
    m_pc = 0; m_halt = 0;
    chk("start_busy", int'(busy), 1);
    chk("start_pc", int'(pc), 0);
  endtask

  task automatic fetch_half();
    @(posedge clk); @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    chk("fetch_opcode", int'(op_code), m_mem[m_pc]);
    chk("fetch_busy", int'(busy), 1);
  endtask

  task automatic exec_half();
    @(posedge clk); @(negedge clk);
    m_step();
    chk("exec_pc", int'(pc), m_pc);
    chk("exec_out", int'(out_data), m_out);
    chk("exec_z", int'(flag_z), m_z);
    chk("exec_c", int'(flag_c), m_c);
    chk("exec_halted", int'(halted), m_halt);
    chk("exec_busy", int'(busy), 1 - m_halt);
  endtask

  // Up to max instructions; optional start/prog_we injection while busy
  task automatic run(input int max, input int inj_at = -1, input int inj_start = 0,
                     input int inj_we = 0, input int inj_addr = 0, input int inj_data = 0);
    for (int i = 0; i < max; i++) begin
      if (i == inj_at) begin
        start      = (inj_start != 0);
        prog_we    = (inj_we != 0);
        prog_addr  = inj_addr[AW-1:0];
        prog_wdata = inj_data[IW-1:0];
      end
      fetch_half();
      exec_half();
      if (m_halt != 0) break;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    for (int a = 0; a < PDEPTH; a++) load(a, '0);

    // All-NOP program: pc wraps 15 -> 0 while busy stays high
    start_run();
    run(20);
    chk("nop_wrap_pc", int'(pc), 4);
    do_reset();

    // 9 + 8 overflows to 1 with carry, halts after 10 busy cycles
    load(0, enc(1, 0, 0, 9));
    load(1, enc(1, 1, 0, 8));
    load(2, enc(4, 0, 1, 0));
    load(3, enc(9, 0, 0, 0));
    load(4, enc(13, 0, 0, 0));
    start_run();
    run(5);
    chk("add_out", int'(out_data), 1);
    chk("add_c", int'(flag_c), 1);
    chk("add_halted", int'(halted), 1);

    // Restart from HALT with a same-cycle write to address 0; r1 survives
    start_run(1, 0, enc(9, 1, 0, 0));
    fetch_half(); exec_half();
    chk("restart_out_r1", int'(out_data), 8);
    run(4);

    // Writes while busy are dropped; re-run proves HLT at 4 is intact
    start_run();
    run(5, 1, 0, 1, 4, 0);
    start_run();
    run(5);
    chk("we_busy_halted", int'(halted), 1);

    // SUB r0,r0 sets Z; JZ immediately follows and takes it
    load(0, enc(5, 0, 0, 0));
    load(1, enc(11, 0, 0, 7));
    load(7, enc(13, 0, 0, 0));
    start_run();
    fetch_half(); exec_half();
    fetch_half(); exec_half();
    chk("jz_pc", int'(pc), 7);
    chk("jz_z", int'(flag_z), 1);
    run(1);

    // IN then OUT, with a start pulse mid-run that must be ignored
    in_data = 4'hA;
    load(0, enc(2, 2, 0, 0));
    load(1, enc(9, 2, 0, 0));
    load(2, enc(13, 0, 0, 0));
    start_run();
    run(3, 1, 1);
    chk("in_out", int'(out_data), 'hA);

    // Reset lands during the EXEC cycle of an ADD
    load(0, enc(1, 0, 0, 3));
    load(1, enc(1, 1, 0, 2));
    load(2, enc(4, 0, 1, 0));
    load(3, enc(9, 0, 0, 0));
    load(4, enc(13, 0, 0, 0));
    start_run();
    run(2);
    fetch_half();
    do_reset();
    load(0, enc(9, 0, 0, 0));
    load(1, enc(13, 0, 0, 0));
    start_run();
    run(2);
    chk("abort_r0", int'(out_data), 0);

    // Random programs
    for (int t = 0; t < 8; t++) begin
      do_reset();
      in_data = DW'($urandom_range(0, 15));
      for (int a = 0; a < PDEPTH; a++) load(a, IW'($urandom_range(0, 4095)));
      start_run();
      run(40);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
